// File: rtl/ntt_level_sequencer.sv
// NTT/INTT butterfly level sequencer: walks the butterfly length from LEN_MAX down to
// LEN_MIN, issuing N/2 stallable butterfly indices per level with a fixed flush gap between.
module ntt_level_sequencer #(
  parameter int N         = 256,
  parameter int LEN_MAX   = 128,
  parameter int LEN_MIN   = 2,
  parameter int LEVEL_GAP = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stall,
  output logic                   server_counter_start,
  output logic [8:0]             startlevel,
  output logic [$clog2(N)-2:0]   bf_idx,
  output logic                   bf_valid,
  output logic [2:0]             level_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = $clog2(N) - 1;
  localparam int GW = (LEVEL_GAP > 1) ? $clog2(LEVEL_GAP) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N/2 - 1);
  localparam logic [8:0]    SL_MAX   = 9'(LEN_MAX);
  localparam logic [8:0]    SL_MIN   = 9'(LEN_MIN);
  localparam logic [GW-1:0] GAP_LOAD = GW'(LEVEL_GAP - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [8:0]      sl_d;
  logic [IW-1:0]   idx_d;
  logic [2:0]      lc_d;
  logic            scs_d, vld_d, busy_d, done_d;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    sl_d    = startlevel;
    idx_d   = bf_idx;
    lc_d    = level_cnt;
    scs_d   = server_counter_start;
    vld_d   = bf_valid;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          sl_d    = SL_MAX;
          lc_d    = '0;
          busy_d  = 1'b1;
        end
      end
      // startlevel settles here while server_counter_start is still low
      LOAD: begin
        state_d = RUN;
        scs_d   = 1'b1;
        vld_d   = 1'b1;
        idx_d   = '0;
      end
      RUN: begin
        if (!stall) begin
          if (bf_idx == IDX_LAST) begin
            state_d = GAP;
            vld_d   = 1'b0;
            gap_d   = GAP_LOAD;
          end else begin
            idx_d = bf_idx + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (startlevel == SL_MIN) begin
          state_d = DONE;
          scs_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
          sl_d    = startlevel >> 1;
          lc_d    = level_cnt + 1'b1;
          idx_d   = '0;
          vld_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q              <= IDLE;
      gap_q                <= '0;
      startlevel           <= '0;
      bf_idx               <= '0;
      level_cnt            <= '0;
      server_counter_start <= 1'b0;
      bf_valid             <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      state_q              <= state_d;
      gap_q                <= gap_d;
      startlevel           <= sl_d;
      bf_idx               <= idx_d;
      level_cnt            <= lc_d;
      server_counter_start <= scs_d;
      bf_valid             <= vld_d;
      busy                 <= busy_d;
      done                 <= done_d;
    end
  end

endmodule

// File: tb/tb_ntt_level_sequencer.sv
// Bench for ntt_level_sequencer: a default instance and a one-level instance share stimulus
// and are checked every cycle against a progress-count model of the transform.
module tb_ntt_level_sequencer;

  logic clk = 1'b0;
  logic rst_n, start, stall;
  always #5 clk = ~clk;

  logic       d1_scs, d1_vld, d1_busy, d1_done;
  logic [8:0] d1_sl;
  logic [6:0] d1_idx;
  logic [2:0] d1_lc;
  logic       d2_scs, d2_vld, d2_busy, d2_done;
  logic [8:0] d2_sl;
  logic [6:0] d2_idx;
  logic [2:0] d2_lc;

  ntt_level_sequencer dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .server_counter_start(d1_scs), .startlevel(d1_sl), .bf_idx(d1_idx),
    .bf_valid(d1_vld), .level_cnt(d1_lc), .busy(d1_busy), .done(d1_done));

  ntt_level_sequencer #(.N(256), .LEN_MAX(4), .LEN_MIN(4), .LEVEL_GAP(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .server_counter_start(d2_scs), .startlevel(d2_sl), .bf_idx(d2_idx),
    .bf_valid(d2_vld), .level_cnt(d2_lc), .busy(d2_busy), .done(d2_done));

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Model: t counts cycles of forward progress since the start edge; every output is a
  // function of t (LOAD at t=0, then L levels of H run + G gap cycles, then DONE).
  typedef struct {
    bit act; int t; int sl; int lc; int idx;
    bit scs; bit vld; bit busy; bit done;
  } mdl_t;

  function automatic mdl_t mstep(mdl_t m, int H, int G, int L, int LMAX, int LMIN,
                                 bit rn, bit st, bit sa);
    mdl_t n;
    int p, lvl, r;
    bit hold;
    n = m;
    if (!rn) begin
      n = '{default:0};
      return n;
    end
    if (!m.act) begin
      if (!st) return n;
      n.act = 1'b1;
      n.t   = 0;
    end else begin
      p    = m.t - 1;
      hold = sa && (m.t >= 1) && (p / (H + G) < L) && (p % (H + G) < H);
      if (!hold) n.t = m.t + 1;
      if (n.t > 1 + L * (H + G)) begin
        n.act = 0; n.scs = 0; n.vld = 0; n.busy = 0; n.done = 0;
        return n;
      end
    end
    n.busy = 1; n.done = 0; n.scs = 0; n.vld = 0;
    if (n.t == 0) begin
      n.sl = LMAX;
      n.lc = 0;
    end else begin
      p = n.t - 1; lvl = p / (H + G); r = p % (H + G);
      if (lvl < L) begin
        n.sl  = LMAX >> lvl;
        n.lc  = lvl;
        n.scs = 1;
        if (r < H) begin n.vld = 1; n.idx = r; end
      end else begin
        n.done = 1;
      end
    end
    return n;
  endfunction

  localparam int L1 = $clog2(128 / 2) + 1;

  mdl_t m1 = '{default:0};
  mdl_t m2 = '{default:0};
  int cyc = 0, t0_1 = 0, t0_2 = 0, lat1 = -1, lat2 = -1, vcnt1 = 0;
  int k1 = 0; bit pscs1 = 0; int psl1 = 0;

  task automatic cmp(string tag, int sl, int lc, int idx, bit scs, bit vld, bit bsy, bit dn,
                     mdl_t m);
    chk({tag, ".startlevel"}, sl, m.sl);
    chk({tag, ".level_cnt"}, lc, m.lc);
    chk({tag, ".bf_idx"}, idx, m.idx);
    chk({tag, ".scs"}, scs, m.scs);
    chk({tag, ".bf_valid"}, vld, m.vld);
    chk({tag, ".busy"}, bsy, m.busy);
    chk({tag, ".done"}, dn, m.done);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      m1 = mstep(m1, 128, 4, L1, 128, 2, rst_n, start, stall);
      m2 = mstep(m2, 128, 1, 1, 4, 4, rst_n, start, stall);
      if (m1.act && m1.t == 0) begin t0_1 = cyc; vcnt1 = 0; end
      if (m2.act && m2.t == 0) t0_2 = cyc;
      @(negedge clk);
      cmp("dut1", d1_sl, d1_lc, d1_idx, d1_scs, d1_vld, d1_busy, d1_done, m1);
      cmp("dut2", d2_sl, d2_lc, d2_idx, d2_scs, d2_vld, d2_busy, d2_done, m2);
      if (d1_done) lat1 = cyc - t0_1;
      if (d2_done) lat2 = cyc - t0_2;
      if (d1_vld) vcnt1++;
      // a k_generate downstream counts scs rising plus each startlevel change while high
      if (!d1_scs) k1 = 0;
      else if (!pscs1 || int'(d1_sl) != psl1) k1++;
      pscs1 = d1_scs; psl1 = int'(d1_sl);
      if (d1_vld) chk("dut1.k", k1, int'(d1_lc) + 1);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(string name);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      seen = d1_done;
    end
    if (!seen) chk({name, ".done_timeout"}, 0, 1);
  endtask

  task automatic check_zero(string name);
    chk({name, ".sl"}, d1_sl, 0);   chk({name, ".lc"}, d1_lc, 0);
    chk({name, ".idx"}, d1_idx, 0); chk({name, ".scs"}, d1_scs, 0);
    chk({name, ".vld"}, d1_vld, 0); chk({name, ".busy"}, d1_busy, 0);
    chk({name, ".done"}, d1_done, 0);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) tick();
    check_zero("reset_idle");

    // nominal: 7 levels of 128+4 cycles after the LOAD cycle
    pulse_start();
    wait_done("nominal");
    @(negedge clk); #1;
    chk("nominal.latency", lat1, 925);
    chk("sweep.latency", lat2, 130);
    chk("nominal.valid_count", vcnt1, 896);
    chk("nominal.final_sl", d1_sl, 2);

    // five stalls at index 37 of level 2, random stalls during gaps
    repeat (3) tick();
    pulse_start();
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      found = (d1_lc == 3'd1) && (d1_idx == 7'd37) && d1_vld;
      if (!found) tick();
    end
    chk("stall.reach_idx37", found, 1);
    stall = 1'b1;
    repeat (5) begin
      tick();
      chk("stall.hold_idx", d1_idx, 37);
      chk("stall.hold_vld", d1_vld, 1);
    end
    stall = 1'b0;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      found = d1_done;
      stall = (d1_busy && !d1_vld) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    stall = 1'b0;
    chk("stall.done_seen", found, 1);
    @(negedge clk); #1;
    chk("stall.latency", lat1, 930);

    // start while busy: mid-run and during DONE
    repeat (3) tick();
    pulse_start();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      found = (d1_lc == 3'd0) && (d1_idx == 7'd10) && d1_vld;
      if (!found) tick();
    end
    chk("busy_start.reach_idx10", found, 1);
    pulse_start();
    wait_done("busy_start");
    pulse_start();
    chk("busy_start.idle_busy", d1_busy, 0);
    chk("busy_start.idle_done", d1_done, 0);
    repeat (3) tick();
    chk("busy_start.stays_idle", d1_busy, 0);
    chk("busy_start.latency", lat1, 925);
    chk("busy_start.valid_count", vcnt1, 896);

    // reset in the gap after level index 3, then restart
    pulse_start();
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      found = (d1_lc == 3'd3) && d1_busy && d1_scs && !d1_vld;
      if (!found) tick();
    end
    chk("midreset.reach_gap", found, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_zero("midreset");
    pulse_start();
    chk("restart.sl", d1_sl, 128);
    chk("restart.lc", d1_lc, 0);
    chk("restart.busy", d1_busy, 1);
    wait_done("restart");
    @(negedge clk); #1;
    chk("restart.latency", lat1, 925);

    // random traffic: stalls, stray starts and rare resets, checked by the model
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < 1500; c++) begin
        stall = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 40) == 0);
        rst_n = ($urandom_range(0, 1999) != 0);
        tick();
      end
      stall = 1'b0; start = 1'b0; rst_n = 1'b1;
      found = 0;
      for (int i = 0; i < 3000 && !found; i++) begin
        tick();
        found = !d1_busy && !d2_busy;
      end
      chk("random.drain", found, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
